// File: rtl/code_select_fsm.sv
// ---------------------------------------------------------------------------
// code_select_fsm
//
// Turns four debounced button levels into a registered 4-bit selection code
// for the seven-segment decoder. The user browses codes 0..MAX_CODE with
// next/prev, which wrap around at both ends. A confirm press holds the
// selection, with the decimal point lit, for HOLD_CYCLES. An inactivity
// timeout of TIMEOUT_CYCLES returns the browser to idle. Cancel always returns
// to idle.
//
// Parameters
//   MAX_CODE        highest selectable code (1..15), also the wrap point
//   TIMEOUT_CYCLES  idle cycles in BROWSE before the return to IDLE (>=2)
//   HOLD_CYCLES     cycles spent in CONFIRM before the return to IDLE (>=1)
//   CNT_W           timer width; must hold max(TIMEOUT_CYCLES,HOLD_CYCLES)-1
//
// Ports
//   clk          in   system clock; all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   btn_next     in   step-up button level
//   btn_prev     in   step-down button level
//   btn_confirm  in   confirm button level
//   btn_cancel   in   cancel button level
//   code         out  current selection (0..MAX_CODE)
//   enable       out  decoder enable; high in BROWSE and CONFIRM
//   decimal      out  decimal-point strobe; high only in CONFIRM
//   confirmed    out  one-cycle pulse on entry to CONFIRM
//   state_o      out  00 IDLE, 01 BROWSE, 10 CONFIRM
// ---------------------------------------------------------------------------
module code_select_fsm #(
    parameter int MAX_CODE       = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 500,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    output logic [3:0] code,
    output logic       enable,
    output logic       decimal,
    output logic       confirmed,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BROWSE  = 2'b01,
        ST_CONFIRM = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    localparam int BTN_NEXT    = 0;
    localparam int BTN_PREV    = 1;
    localparam int BTN_CONFIRM = 2;
    localparam int BTN_CANCEL  = 3;

    localparam logic [3:0]       CODE_MAX     = 4'(MAX_CODE);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [3:0]       code_reg, code_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             confirmed_reg, confirmed_next;
    logic [3:0]       btn_q_reg;
    logic [3:0]       btn_vec;
    logic [3:0]       press;

    assign btn_vec = {btn_cancel, btn_confirm, btn_prev, btn_next};

    // A press is a rising edge of the level. The history resets to all ones,
    // so a button held through reset release produces no press until it has
    // been released once.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_press
            assign press[gi] = btn_vec[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            code_reg      <= 4'd0;
            timer_reg     <= '0;
            confirmed_reg <= 1'b0;
            btn_q_reg     <= 4'b1111;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            timer_reg     <= timer_next;
            confirmed_reg <= confirmed_next;
            btn_q_reg     <= btn_vec;
        end
    end

    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        timer_next     = timer_reg;
        confirmed_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                code_next  = 4'd0;
                timer_next = '0;
                // Cancel outranks everything, so a cancel press in IDLE
                // also swallows a simultaneous wake press. The wake press
                // itself does not step the code.
                if (!press[BTN_CANCEL] &&
                    (press[BTN_NEXT] || press[BTN_PREV] || press[BTN_CONFIRM])) begin
                    state_next = ST_BROWSE;
                end
            end

            ST_BROWSE: begin
                if (press[BTN_CANCEL]) begin
                    state_next = ST_IDLE;
                    code_next  = 4'd0;
                    timer_next = '0;
                end else if (press[BTN_CONFIRM]) begin
                    state_next     = ST_CONFIRM;
                    confirmed_next = 1'b1;
                    timer_next     = '0;
                end else if (press[BTN_NEXT] || press[BTN_PREV]) begin
                    // next and prev together count as activity without a step.
                    timer_next = '0;
                    if (press[BTN_NEXT] && !press[BTN_PREV]) begin
                        code_next = (code_reg >= CODE_MAX) ? 4'd0 : code_reg + 4'd1;
                    end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
                        code_next = (code_reg == 4'd0) ? CODE_MAX : code_reg - 4'd1;
                    end
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = ST_IDLE;
                    code_next  = 4'd0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_CONFIRM: begin
                // The code stays frozen. next/prev/confirm do not extend the hold.
                if (press[BTN_CANCEL] || timer_reg == HOLD_LAST) begin
                    state_next = ST_IDLE;
                    code_next  = 4'd0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                code_next  = 4'd0;
                timer_next = '0;
            end
        endcase
    end

    // Every output is taken directly from a register, so there is no
    // combinational path from a button to an output.
    assign code      = code_reg;
    assign state_o   = state_reg;
    assign confirmed = confirmed_reg;
    assign enable    = (state_reg == ST_BROWSE) || (state_reg == ST_CONFIRM);
    assign decimal   = (state_reg == ST_CONFIRM);

endmodule

// File: tb/tb_code_select_fsm.sv
module tb_code_select_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_prev, btn_confirm, btn_cancel;
    logic [3:0] code;
    logic       enable, decimal, confirmed;
    logic [1:0] state_o;

    int tests_run = 0;
    int tests_failed = 0;

    code_select_fsm #(
        .MAX_CODE      (8),
        .TIMEOUT_CYCLES(10),
        .HOLD_CYCLES   (4),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_confirm(btn_confirm),
        .btn_cancel (btn_cancel),
        .code       (code),
        .enable     (enable),
        .decimal    (decimal),
        .confirmed  (confirmed),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] cd,
                           input logic en, input logic dp, input logic cf);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".code"}, 32'(code), 32'(cd));
        chk({tag, ".enable"}, 32'(enable), 32'(en));
        chk({tag, ".decimal"}, 32'(decimal), 32'(dp));
        chk({tag, ".confirmed"}, 32'(confirmed), 32'(cf));
    endtask

    // One press: the level is high for one sampling edge, then low for one edge.
    task automatic press(input logic n, input logic p, input logic cf, input logic cn);
        btn_next = n; btn_prev = p; btn_confirm = cf; btn_cancel = cn;
        tick();
        btn_next = 0; btn_prev = 0; btn_confirm = 0; btn_cancel = 0;
        tick();
    endtask

    initial begin
        rst_n = 0; btn_next = 1; btn_prev = 0; btn_confirm = 0; btn_cancel = 0;

        // 1: reset, with next held through the release
        repeat (3) tick();
        chk_all("reset", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1;
        repeat (5) tick();
        chk_all("held_thru_reset", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        btn_next = 0;
        tick();
        chk("after_release.state", 32'(state_o), 32'd0);

        // 2: wake without a step, then step up with wrap, then prev at 0
        press(1, 0, 0, 0);
        chk_all("wake", 2'b01, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            press(1, 0, 0, 0);
            chk($sformatf("next_%0d.code", i), 32'(code), (i == 9) ? 32'd0 : 32'(i));
        end
        press(0, 1, 0, 0);
        chk("prev_wrap.code", 32'(code), 32'd8);
        press(0, 1, 0, 0);
        chk("prev_step.code", 32'(code), 32'd7);

        // 3: confirm at code 5, next ignored, hold of 4 cycles
        press(1, 0, 0, 0);   // 8
        press(1, 0, 0, 0);   // 0
        repeat (5) press(1, 0, 0, 0);
        chk("pre_confirm.code", 32'(code), 32'd5);
        btn_confirm = 1;
        tick();              // edge k
        chk_all("confirm_k", 2'b10, 4'd5, 1'b1, 1'b1, 1'b1);
        btn_confirm = 0; btn_next = 1;
        tick();              // k+1
        chk_all("confirm_k1", 2'b10, 4'd5, 1'b1, 1'b1, 1'b0);
        btn_next = 0;
        tick(); tick();      // k+3
        chk("confirm_k3.state", 32'(state_o), 32'd2);
        tick();              // k+4
        chk_all("confirm_done", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);

        // 4a: timeout with no presses
        btn_next = 1;
        tick();              // enter BROWSE at edge k
        btn_next = 0;
        repeat (9) tick();   // k+9
        chk("timeout_k9.state", 32'(state_o), 32'd1);
        tick();              // k+10
        chk_all("timeout_k10", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);

        // 4b: a press at k+8 restarts the timeout
        btn_next = 1;
        tick();              // k
        btn_next = 0;
        repeat (7) tick();   // k+7
        btn_next = 1;
        tick();              // k+8
        btn_next = 0;
        chk("restart_k8.code", 32'(code), 32'd1);
        repeat (9) tick();   // k+17
        chk("restart_k17.state", 32'(state_o), 32'd1);
        tick();              // k+18
        chk("restart_k18.state", 32'(state_o), 32'd0);
        chk("restart_k18.code", 32'(code), 32'd0);

        // 5: next+prev together, then confirm+cancel together
        press(1, 0, 0, 0);   // wake
        repeat (3) press(1, 0, 0, 0);
        press(1, 1, 0, 0);
        chk("next_prev.code", 32'(code), 32'd3);
        chk("next_prev.state", 32'(state_o), 32'd1);
        btn_confirm = 1; btn_cancel = 1;
        tick();
        chk_all("conf_cancel", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        btn_confirm = 0; btn_cancel = 0;
        tick();
        chk("conf_cancel_after.confirmed", 32'(confirmed), 32'd0);

        // cancel alone in BROWSE and in CONFIRM
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);   // code 8
        press(0, 0, 0, 1);
        chk_all("browse_cancel", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);   // code 1
        press(0, 0, 1, 0);   // CONFIRM entered, released
        chk_all("confirm_hold", 2'b10, 4'd1, 1'b1, 1'b1, 1'b0);
        btn_cancel = 1;
        tick();
        chk_all("confirm_cancel", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        btn_cancel = 0;
        tick();

        // 6: reset while in CONFIRM
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);   // code 1
        btn_confirm = 1;
        tick();
        chk("pre_reset.confirmed", 32'(confirmed), 32'd1);
        btn_confirm = 0;
        tick();
        rst_n = 0;
        tick();
        chk_all("reset_in_confirm", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1;
        tick();
        chk("post_reset.state", 32'(state_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
